// File: rtl/pulse_freq_meter_if.sv
// Signal bundle between the pulse generator side and pulse_freq_meter.
// The master drives Pulse; the meter (slave) returns the measurement.
interface pulse_freq_meter_if #(
    parameter int CNT_W = 16
) ();
    logic             Pulse;
    logic [CNT_W-1:0] Freq_Count;
    logic [15:0]      Freq_BCD;
    logic             Overflow;
    logic             Valid;

    modport master (
        output Pulse,
        input  Freq_Count, Freq_BCD, Overflow, Valid
    );

    modport slave (
        input  Pulse,
        output Freq_Count, Freq_BCD, Overflow, Valid
    );
endinterface

// File: rtl/pulse_freq_meter.sv
// Counts rising edges of Pulse over a GATE_CYCLES window; reports binary + 4-digit BCD.
// Optional macro FREQ_METER_SYNC_EN inserts a 2-flop synchronizer on Pulse.
module pulse_freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    pulse_freq_meter_if.slave meter
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    logic pulse_s;
    logic pulse_live;

`ifdef FREQ_METER_SYNC_EN
    logic sync1, sync2;
    logic fill1, fill2;

    // fill tracks when the synchronizer holds a real sample rather than reset zeros
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            fill1 <= 1'b0;
            fill2 <= 1'b0;
        end else begin
            sync1 <= meter.Pulse;
            sync2 <= sync1;
            fill1 <= 1'b1;
            fill2 <= fill1;
        end
    end

    always_comb begin
        pulse_s    = sync2;
        pulse_live = fill2;
    end
`else
    always_comb begin
        pulse_s    = meter.Pulse;
        pulse_live = 1'b1;
    end
`endif

    logic pulse_d;
    logic primed;
    logic edge_det;

    // primed: a genuine low must be seen first, so a level high at reset release is no edge
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            pulse_d <= 1'b0;
            primed  <= 1'b0;
        end else begin
            pulse_d <= pulse_s;
            if (pulse_live && !pulse_s) begin
                primed <= 1'b1;
            end
        end
    end

    always_comb begin
        edge_det = pulse_s & ~pulse_d & primed;
    end

    logic [GATE_W-1:0] gate;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [31:0]       count_ext;
    logic              terminal;
    logic              over;
    logic [15:0]       bin_load;

    always_comb begin
        terminal  = (gate == GATE_LAST);
        cnt_inc   = (edge_det && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;
        count_ext = 32'(cnt_inc);
        over      = (count_ext > 32'd9999);
        bin_load  = over ? 16'd9999 : count_ext[15:0];
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            gate             <= '0;
            edge_cnt         <= '0;
            meter.Freq_Count <= '0;
        end else begin
            if (terminal) begin
                gate             <= '0;
                edge_cnt         <= '0;
                meter.Freq_Count <= cnt_inc;
            end else begin
                gate     <= gate + GATE_W'(1);
                edge_cnt <= cnt_inc;
            end
        end
    end

    state_t      state, state_next;
    logic [3:0]  shift_cnt;
    logic [15:0] bin;
    logic [14:0] bcd;
    logic [11:0] adj;
    logic        ovf_cap;
    logic        shift_en;
    logic        last_shift;

    // The thousands digit is at most 4 before any shift (value <= 9999), so it
    // never needs the +3 step and bcd only has to hold 15 bits between shifts.
    always_comb begin
        state_next  = state;
        shift_en    = 1'b0;
        meter.Valid = 1'b0;
        last_shift  = (shift_cnt == 4'd15);
        adj         = bcd[11:0];
        for (int unsigned n = 0; n < 3; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
            end
        end
        case (state)
            IDLE: begin
                if (terminal) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                shift_en = 1'b1;
                if (last_shift) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                meter.Valid = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            shift_cnt      <= '0;
            bin            <= '0;
            bcd            <= '0;
            ovf_cap        <= 1'b0;
            meter.Freq_BCD <= '0;
            meter.Overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && terminal) begin
                bin       <= bin_load;
                bcd       <= '0;
                ovf_cap   <= over;
                shift_cnt <= '0;
            end
            if (shift_en) begin
                bcd       <= {bcd[13:12], adj, bin[15]};
                bin       <= {bin[14:0], 1'b0};
                shift_cnt <= shift_cnt + 4'd1;
                if (last_shift) begin
                    meter.Freq_BCD <= {bcd[14:12], adj, bin[15]};
                    meter.Overflow <= ovf_cap;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Runs several meter instances side by side against a window-counting model
// of the Pulse waveform, plus literal expectations for each instance's first result.
module tb_pulse_freq_meter;

`ifdef FREQ_METER_SYNC_EN
    localparam int L = 2;
    localparam int LIT2 = 10004;
`else
    localparam int L = 0;
    localparam int LIT2 = 10005;
`endif

    localparam int N = 5;
    // 0: window count (+ reset mid-conversion), 1: window boundary, 2: overflow clamp,
    // 3: counter saturation with CNT_W=8, 4: static high input
    localparam int GS  [N] = '{1000, 64, 20010, 600, 64};
    localparam int CWS [N] = '{16, 16, 16, 8, 16};
    localparam int LIT_CNT [N] = '{100, 1, LIT2, 255, 0};
    localparam int LIT_BCD [N] = '{'h0100, 'h0001, 'h9999, 'h0255, 'h0000};
    localparam int LIT_OVF [N] = '{0, 0, 1, 0, 0};

    logic clk;
    int   pass_cnt;
    int   total_cnt;
    logic lit_seen [N];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic pat(input int k, input int c);
        case (k)
            0:       return (c % 10) >= 5;
            1:       return (c == 63 - L) || (c == 65 - L) || (c == 128 - L) || (c == 191 - L);
            2, 3:    return c[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] bcd_of(input int v);
        int x;
        x = (v > 9999) ? 9999 : v;
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_dut
        localparam int G  = GS[i];
        localparam int CW = CWS[i];

        logic rst;
        pulse_freq_meter_if #(.CNT_W(CW)) bus ();

        pulse_freq_meter #(.GATE_CYCLES(G), .CNT_W(CW)) dut (
            .sysclk (clk),
            .reset  (rst),
            .meter  (bus.slave)
        );

        initial begin
            int c, hold, cnt, last_cnt, pend_t, pend_cnt;
            logic did_mid, pend, exp_valid, exp_ovf;
            logic [15:0] exp_bcd;
            int hist[$];

            lit_seen[i] = 1'b0;
            rst = 1'b0;
            hold = 3;
            did_mid = 1'b0;
            c = 0;
            last_cnt = 0;
            pend = 1'b0;
            pend_t = 0;
            pend_cnt = 0;
            exp_bcd = '0;
            exp_ovf = 1'b0;
            bus.Pulse = pat(i, 0);
            forever begin
                @(negedge clk);
                if (!rst) begin
                    check($sformatf("dut%0d reset cnt", i), int'(bus.Freq_Count), 0);
                    check($sformatf("dut%0d reset bcd", i), int'(bus.Freq_BCD), 0);
                    check($sformatf("dut%0d reset ovf", i), int'(bus.Overflow), 0);
                    check($sformatf("dut%0d reset valid", i), int'(bus.Valid), 0);
                    hold--;
                    if (hold == 0) begin
                        rst = 1'b1;
                        c = 0;
                        hist.delete();
                        last_cnt = 0;
                        pend = 1'b0;
                        exp_bcd = '0;
                        exp_ovf = 1'b0;
                        bus.Pulse = pat(i, 0);
                        hist.push_back(int'(pat(i, 0)));
                    end
                end else begin
                    c++;
                    if (c % G == 0) begin
                        cnt = 0;
                        for (int j = c - G - L; j <= c - 1 - L; j++) begin
                            if (j >= 1 && hist[j] == 1 && hist[j-1] == 0) cnt++;
                        end
                        if (cnt > (1 << CW) - 1) cnt = (1 << CW) - 1;
                        last_cnt = cnt;
                        pend = 1'b1;
                        pend_t = c - 1;
                        pend_cnt = cnt;
                    end
                    exp_valid = pend && (c == pend_t + 17);
                    if (exp_valid) begin
                        exp_bcd = bcd_of(pend_cnt);
                        exp_ovf = (pend_cnt > 9999);
                        pend = 1'b0;
                    end
                    check($sformatf("dut%0d cnt c=%0d", i, c), int'(bus.Freq_Count), last_cnt);
                    check($sformatf("dut%0d bcd c=%0d", i, c), int'(bus.Freq_BCD), int'(exp_bcd));
                    check($sformatf("dut%0d ovf c=%0d", i, c), int'(bus.Overflow), int'(exp_ovf));
                    check($sformatf("dut%0d valid c=%0d", i, c), int'(bus.Valid), int'(exp_valid));
                    if (bus.Valid && !lit_seen[i]) begin
                        lit_seen[i] = 1'b1;
                        check($sformatf("dut%0d lit cnt", i), int'(bus.Freq_Count), LIT_CNT[i]);
                        check($sformatf("dut%0d lit bcd", i), int'(bus.Freq_BCD), LIT_BCD[i]);
                        check($sformatf("dut%0d lit ovf", i), int'(bus.Overflow), LIT_OVF[i]);
                        check($sformatf("dut%0d lit c", i), c, G - 1 + 17);
                    end
                    if (i == 0 && !did_mid && c == G - 1 + 8) begin
                        did_mid = 1'b1;
                        rst = 1'b0;
                        hold = 3;
                        bus.Pulse = pat(i, 0);
                    end else begin
                        bus.Pulse = pat(i, c);
                        hist.push_back(int'(pat(i, c)));
                    end
                end
            end
        end
    end

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        repeat (20100) @(negedge clk);
        #2;
        for (int k = 0; k < N; k++) begin
            check($sformatf("dut%0d result seen", k), int'(lit_seen[k]), 1);
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pulse_freq_meter.md
# pulse_freq_meter

Measures the output frequency of the waveform stage. It counts rising edges of the generated `Pulse` over a fixed window of `sysclk` cycles and latches the result as binary and 4-digit BCD. The BCD value drives the board's seven-segment display driver. It sits directly downstream of the `Sum` pulse generator and closes the loop so the user sees the effect of the Plus/Minus frequency buttons.

## Interface
- `GATE_CYCLES`, default 100000000: measurement window length in `sysclk` cycles (1 s at 100 MHz). Must be ≥ 32.
- `CNT_W`, default 16: width of the edge counter and of `Freq_Count`.
- `sysclk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Pulse` in 1: waveform output from the pulse generator.
- `Freq_Count` out CNT_W: edges counted in the last completed window, saturating.
- `Freq_BCD` out 16: four BCD digits of `min(Freq_Count, 9999)`. Bits [15:12] are thousands.
- `Overflow` out 1: high when the last window counted more than 9999 edges.
- `Valid` out 1: one-cycle strobe when `Freq_BCD` and `Overflow` update.

## Operation
- Input path: `Pulse` passes through a 2-flop synchronizer (see Configuration), then one edge-detect register. An edge is declared on the cycle where the synchronized value is 1 and its delayed copy is 0.
- Gate counter: runs 0 → `GATE_CYCLES`-1 and wraps. The terminal cycle is gate = `GATE_CYCLES`-1.
- Edge counter:
  - Increments on each detected edge.
  - Saturates at 2^CNT_W − 1 and never wraps.
- Terminal cycle:
  - `Freq_Count` ← edge count, including an edge detected in that same cycle.
  - The edge counter clears to 0.
  - The next window starts at gate = 0, and edges there count into the new window.
- Conversion FSM, states IDLE, CONV, DONE:
  - IDLE → CONV on the terminal cycle. The latched value is clamped to 9999, and the overflow flag is captured (value > 9999).
  - CONV: sequential double-dabble, one shift per cycle, exactly 16 cycles. Each cycle, add 3 to any BCD nibble ≥ 5, then shift left.
  - CONV → DONE after the 16th shift.
  - DONE: load `Freq_BCD` and `Overflow`, assert `Valid`, return to IDLE.
- `Freq_BCD` and `Overflow` hold between updates.
- The FSM cannot be retriggered while busy. This is guaranteed by `GATE_CYCLES` ≥ 32.
- Reset outputs: `Freq_Count`=0, `Freq_BCD`=16'h0000, `Overflow`=0, `Valid`=0.
- Reset internal state: gate=0, edge counter=0, FSM=IDLE, synchronizer and edge-detect flops = 0.
- Reset mid-window or mid-conversion: the partial result is discarded and no `Valid` is issued. After deassertion the first counted cycle is gate=0.
- A `Pulse` that is high at reset release is not an edge, because the edge-detect flop starts at 0 and the input must first be seen low.

## Timing
- Edge latency: a `Pulse` rise sampled at edge k is counted at edge k+3 with the synchronizer, k+1 without it.
- Terminal cycle T: `Freq_Count` is visible from T+1.
- FSM: in CONV for cycles T+1..T+16, in DONE at T+17.
- `Valid`=1 during cycle T+17 only. `Freq_BCD` and `Overflow` are visible from T+17.
- One result is produced every `GATE_CYCLES` cycles.
- Maximum countable edge rate is `sysclk`/2, since the input must be low then high on successive samples.

## Configuration
- `FREQ_METER_SYNC_EN` defined:
  - 2-flop synchronizer on `Pulse`, for use when `Pulse` is asynchronous or from an external pin.
- `FREQ_METER_SYNC_EN` undefined:
  - `Pulse` feeds the edge-detect register directly. It must then be synchronous to `sysclk`, as when driven by the internal divider.
  - Edge latency drops by 2 cycles.
  - Count values are unchanged for steady periodic input.

## Test plan
- Window count: `GATE_CYCLES`=1000, `Pulse` period 10 cycles → every window `Freq_Count`=100, `Freq_BCD`=16'h0100, `Overflow`=0, `Valid` exactly 17 cycles after each terminal cycle.
- Overflow clamp: `GATE_CYCLES`=100000, `Pulse` toggling every cycle → `Freq_Count`=50000, `Freq_BCD`=16'h9999, `Overflow`=1.
- Static input: `Pulse` held 1 from before reset release → `Freq_Count`=0, `Freq_BCD`=16'h0000, with a `Valid` each window.
- Window boundary: `GATE_CYCLES`=64, one edge timed to be detected on the terminal cycle, a second edge detected at gate=0 → first window counts 1, next window counts 1.
- Reset mid-conversion: assert `reset` at T+8 for 3 cycles → no `Valid`, all outputs 0, next `Valid` at the terminal cycle `GATE_CYCLES`-1 after release, +17.
- Macro off: repeat the window-count test without `FREQ_METER_SYNC_EN` → identical counts, edge-to-increment latency 1 cycle.
